acc_frame_ctrl: RTL and testbench
=================================

Name: acc_frame_ctrl

Overview:
- Drives the framing side of the signed accumulator and reads its results.
- Takes a raw signed sample stream and forwards it to the accumulator with a registered acc_done strobe. acc_done marks the first word of each new accumulation; frame length is programmable.
- Captures the accumulator's dout/dout_valid results into a one-entry output register with a valid/ready handshake and a sticky overrun flag.
- Sits between the band-DoA correlator outputs and the software readout / bram writer.

Parameters:
DIN_WIDTH, 16, width of signed input samples
ACC_WIDTH, 32, width of accumulated result returned by the accumulator
LEN_WIDTH, 16, width of accumulation-length input (samples per frame)
CNT_WIDTH, 32, width of the captured-frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
din  in  DIN_WIDTH  signed input sample
din_valid  in  1  input sample qualifier
enable  in  1  run request; level, sampled at frame boundaries
acc_len  in  LEN_WIDTH  samples per accumulation; latched at each frame start
acc_din  out  DIN_WIDTH  sample to accumulator
acc_din_valid  out  1  qualifier to accumulator
acc_done  out  1  first-word-of-new-accumulation strobe to accumulator
acc_dout  in  ACC_WIDTH  accumulator result
acc_dout_valid  in  1  accumulator result strobe
m_dout  out  ACC_WIDTH  captured result
m_valid  out  1  result available
m_ready  in  1  downstream accept
overrun  out  1  sticky: result lost because output register was full
clear_overrun  in  1  synchronous clear of overrun
frame_cnt  out  CNT_WIDTH  number of results captured into m_dout (wraps)
busy  out  1  high in RUN or FLUSH

Behaviour:
- Reset: all outputs 0; state IDLE; length counter 0; discard flag set.
- All outputs to the accumulator are registered. acc_din and acc_din_valid follow din and din_valid with 1-cycle latency. Samples with din_valid=0 are forwarded as acc_din_valid=0 and do not advance the counter.
- Effective length L = acc_len, with acc_len=0 treated as 1. L is latched on the sample that starts a frame; changes mid-frame are ignored.
- State IDLE:
  - acc_din_valid=0.
  - On din_valid & enable: forward the sample with acc_done=1, latch L, set count=1, go to RUN.
  - The discard flag is set here, so the result the accumulator emits for this first acc_done (the stale value) is dropped.
- State RUN, on each din_valid:
  - If count==L and enable=1: forward the sample with acc_done=1 (new frame), relatch L, count=1.
  - If count==L and enable=0: do not forward the sample; go to FLUSH.
  - Otherwise: forward the sample with acc_done=0, count+1.
- State FLUSH:
  - Emit one cycle of acc_din=0, acc_din_valid=1, acc_done=1. This makes the accumulator output the final frame and load 0.
  - Go to IDLE and set the discard flag.
  - Input samples arriving during FLUSH are dropped.
- Result capture:
  - On acc_dout_valid with discard flag set: clear the flag and drop the result.
  - Otherwise, if m_valid=0 or m_ready=1 in the same cycle: m_dout<=acc_dout, m_valid<=1, frame_cnt+1.
  - Otherwise: keep the old m_dout and set overrun.
- Handshake:
  - m_valid drops after a cycle with m_valid & m_ready and no new capture.
  - Capture and accept in the same cycle leaves m_valid=1 holding the new data.
- overrun:
  - Cleared by clear_overrun.
  - If set and clear happen in the same cycle, set wins.
- frame_cnt wraps at 2^CNT_WIDTH.
- Async reset mid-frame: everything returns to the reset state. The next enabled sample starts a new frame with the discard flag set.
- Width rule: the block never widens or sign-extends data. acc_dout is passed through unchanged.

Decomposition:
- Shared package holds:
  - state enum IDLE/RUN/FLUSH
  - default widths DIN_WIDTH/ACC_WIDTH/LEN_WIDTH
  - constant for minimum length 1
- One sub-module is natural: acc_out_reg, the one-entry valid/ready output register with overrun and frame_cnt.
- The framing FSM stays in the top module.

Test Plan:
- enable=1, acc_len=4, din=1..8 continuous, then enable=0:
  - acc_done is high on the forwarded samples 1 and 5 and on the flush word.
  - m_dout=10, then 26.
  - frame_cnt=2; first stale result discarded.
- Same as above with din_valid toggling every other cycle: identical results; count advances only on valid samples.
- acc_len=0 with din=-3,5,7: every sample has acc_done=1; captured m_dout=-3, then 5, then 7 (last via flush).
- m_ready held 0, acc_len=2, din=1..6:
  - first result 3 is held in m_dout.
  - second result (7) is lost and overrun=1.
  - clear_overrun pulse clears it.
  - Then raise m_ready: m_dout=3 accepted, m_valid drops.
- Change acc_len from 4 to 2 mid-frame: the current frame still sums 4 samples; the next frame uses 2.
- Assert rst_n=0 mid-frame at count=2: all outputs 0. After release, the first result is discarded and frame_cnt restarts from 0.

Source files
------------

// File: rtl/acc_frame_ctrl_pkg.sv
// acc_frame_ctrl_pkg
//   Shared types and constants for the accumulator framing controller.
//   frame_state_e : framing FSM states (IDLE / RUN / FLUSH)
//   *_WIDTH_DEF   : default data, result, length and counter widths
//   MIN_ACC_LEN   : effective frame length used when acc_len is programmed to 0
package acc_frame_ctrl_pkg;

    localparam int DIN_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF = 32;

    localparam int MIN_ACC_LEN = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } frame_state_e;

endpackage

// File: rtl/acc_frame_ctrl_out.sv
// acc_frame_ctrl_out
//   One-entry result register between the accumulator and the readout side.
//   Drops the stale result that follows a fresh start, captures the rest
//   under a valid/ready handshake, flags lost results and counts captures.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   discard_arm       arm the drop-next-result flag
//   acc_dout(_valid)  accumulator result and strobe
//   m_dout, m_valid   captured result / result available
//   m_ready           downstream accept
//   clear_overrun     synchronous clear of overrun (a new loss wins)
//   overrun           sticky lost-result flag
//   frame_cnt         number of captured results, wraps
module acc_frame_ctrl_out
    import acc_frame_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 discard_arm,
    input  logic [ACC_WIDTH-1:0] acc_dout,
    input  logic                 acc_dout_valid,
    output logic [ACC_WIDTH-1:0] m_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 clear_overrun,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    logic discard_q;
    logic keep;
    logic capture;
    logic lost;

    assign keep    = acc_dout_valid && !discard_q;
    assign capture = keep && (!m_valid || m_ready);
    assign lost    = keep && m_valid && !m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_q <= 1'b1;
            m_dout    <= '0;
            m_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // Arming wins over consuming: the stale result always trails the arm.
            if (discard_arm) begin
                discard_q <= 1'b1;
            end else if (acc_dout_valid && discard_q) begin
                discard_q <= 1'b0;
            end

            if (capture) begin
                m_dout    <= acc_dout;
                m_valid   <= 1'b1;
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (lost) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acc_frame_ctrl.sv
// acc_frame_ctrl
//   Frames a signed sample stream for the accumulator (registered acc_din,
//   acc_din_valid, acc_done) and hands accumulator results to the readout
//   through a one-entry valid/ready register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   din, din_valid                  raw signed samples
//   enable                          run request, sampled at frame boundaries
//   acc_len                         samples per frame (0 behaves as 1)
//   acc_din, acc_din_valid, acc_done  to accumulator
//   acc_dout, acc_dout_valid        from accumulator
//   m_dout, m_valid, m_ready        result handshake
//   overrun, clear_overrun          sticky lost-result flag and its clear
//   frame_cnt                       captured result count
//   busy                            high in RUN or FLUSH
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | stopped; first enabled valid sample starts a frame
// ST_RUN   | forwarding samples, counting down to the frame boundary
// ST_FLUSH | one zero word with acc_done to push out the final frame
module acc_frame_ctrl
    import acc_frame_ctrl_pkg::*;
#(
    parameter int DIN_WIDTH = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] acc_len,
    output logic [DIN_WIDTH-1:0] acc_din,
    output logic                 acc_din_valid,
    output logic                 acc_done,
    input  logic [ACC_WIDTH-1:0] acc_dout,
    input  logic                 acc_dout_valid,
    output logic [ACC_WIDTH-1:0] m_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 busy
);

    frame_state_e         state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;     // samples still to go after the current one
    logic [LEN_WIDTH-1:0] eff_len;
    logic                 fwd_valid, fwd_done, fwd_zero, idle_start;
    logic                 start_q;

    assign eff_len = (acc_len == '0) ? LEN_WIDTH'(MIN_ACC_LEN) : acc_len;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        fwd_valid  = 1'b0;
        fwd_done   = 1'b0;
        fwd_zero   = 1'b0;
        idle_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid && enable) begin
                    fwd_valid  = 1'b1;
                    fwd_done   = 1'b1;
                    idle_start = 1'b1;
                    rem_d      = eff_len - LEN_WIDTH'(1);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    if (rem_q == '0) begin
                        if (enable) begin
                            fwd_valid = 1'b1;
                            fwd_done  = 1'b1;
                            rem_d     = eff_len - LEN_WIDTH'(1);
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        fwd_valid = 1'b1;
                        rem_d     = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                fwd_valid = 1'b1;
                fwd_done  = 1'b1;
                fwd_zero  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            acc_din       <= '0;
            acc_din_valid <= 1'b0;
            acc_done      <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            acc_din       <= fwd_zero ? '0 : din;
            acc_din_valid <= fwd_valid;
            acc_done      <= fwd_done;
            start_q       <= idle_start;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_FLUSH);

    // The discard flag is armed while the start word is on the accumulator
    // bus, so it takes effect one cycle later: the result for a preceding
    // flush (which can land in that same cycle) is still captured, and the
    // stale result for the start word (one cycle behind) is dropped.
    acc_frame_ctrl_out #(
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out (
        .clk            (clk),
        .rst_n          (rst_n),
        .discard_arm    (start_q),
        .acc_dout       (acc_dout),
        .acc_dout_valid (acc_dout_valid),
        .m_dout         (m_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .clear_overrun  (clear_overrun),
        .overrun        (overrun),
        .frame_cnt      (frame_cnt)
    );

endmodule

// File: tb/tb_acc_frame_ctrl.sv
// Directed bench for acc_frame_ctrl with a behavioural accumulator that
// returns the running sum one cycle after each acc_done word.
module tb_acc_frame_ctrl;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] acc_len = '0;
    logic [DW-1:0] acc_din;
    logic          acc_din_valid;
    logic          acc_done;
    logic [AW-1:0] acc_dout;
    logic          acc_dout_valid;
    logic [AW-1:0] m_dout;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          overrun;
    logic          clear_overrun = 1'b0;
    logic [CW-1:0] frame_cnt;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acc_frame_ctrl #(
        .DIN_WIDTH (DW),
        .ACC_WIDTH (AW),
        .LEN_WIDTH (LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din            (din),
        .din_valid      (din_valid),
        .enable         (enable),
        .acc_len        (acc_len),
        .acc_din        (acc_din),
        .acc_din_valid  (acc_din_valid),
        .acc_done       (acc_done),
        .acc_dout       (acc_dout),
        .acc_dout_valid (acc_dout_valid),
        .m_dout         (m_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun),
        .frame_cnt      (frame_cnt),
        .busy           (busy)
    );

    // Accumulator model: acc_done outputs the old sum and loads the new word.
    logic [AW-1:0] sum;
    logic          model_clr = 1'b1;
    always @(posedge clk) begin
        if (model_clr) begin
            sum            <= '0;
            acc_dout       <= '0;
            acc_dout_valid <= 1'b0;
        end else begin
            acc_dout_valid <= 1'b0;
            if (acc_din_valid) begin
                if (acc_done) begin
                    acc_dout       <= sum;
                    acc_dout_valid <= 1'b1;
                    sum            <= {{(AW-DW){acc_din[DW-1]}}, acc_din};
                end else begin
                    sum <= sum + {{(AW-DW){acc_din[DW-1]}}, acc_din};
                end
            end
        end
    end

    // Monitor: acc_done words and accepted results, logged in arrival order.
    logic [DW-1:0] done_q[$];
    logic [AW-1:0] cap_q[$];
    int            fwd_cnt = 0;
    always @(negedge clk) begin
        if (acc_din_valid) fwd_cnt++;
        if (acc_din_valid && acc_done) done_q.push_back(acc_din);
        if (m_valid && m_ready) cap_q.push_back(m_dout);
    end

    int done_base, cap_base, fwd_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v, input logic en);
        tick();
        din       = d;
        din_valid = v;
        enable    = en;
    endtask

    task automatic idle(input int n);
        repeat (n) send('0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick();
        rst_n         = 1'b0;
        model_clr     = 1'b1;
        din_valid     = 1'b0;
        enable        = 1'b0;
        clear_overrun = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        model_clr = 1'b0;
        done_base = done_q.size();
        cap_base  = cap_q.size();
        fwd_base  = fwd_cnt;
    endtask

    task automatic test_reset();
        logic [DW+AW+CW+5-1:0] outs;
        tick();
        rst_n     = 1'b0;
        model_clr = 1'b1;
        tick();
        outs = {acc_din, acc_din_valid, acc_done, m_dout, m_valid, overrun, frame_cnt, busy};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick();
        rst_n     = 1'b1;
        model_clr = 1'b0;
        send(16'h0055, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (acc_din_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_enable: got valid=%b busy=%b expected 0 0", acc_din_valid, busy);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_done[$];
        logic [AW-1:0] exp_cap[$];
        exp_done = '{16'd1, 16'd5, 16'd0};
        exp_cap  = '{32'd10, 32'd26};
        do_reset();
        acc_len = 16'd4;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i), 1'b1, 1'b1);
        send(16'd9, 1'b1, 1'b0);
        idle(6);
        n_checks++;
        if (done_q.size() - done_base !== exp_done.size()) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d expected %0d", done_q.size() - done_base, exp_done.size());
        end
        foreach (exp_done[i]) begin
            n_checks++;
            if (done_base + i >= done_q.size() || done_q[done_base + i] !== exp_done[i]) begin
                n_fail++;
                $display("FAIL basic_done[%0d]: got %h expected %h", i,
                         (done_base + i < done_q.size()) ? done_q[done_base + i] : 'x, exp_done[i]);
            end
        end
        foreach (exp_cap[i]) begin
            n_checks++;
            if (cap_base + i >= cap_q.size() || cap_q[cap_base + i] !== exp_cap[i]) begin
                n_fail++;
                $display("FAIL basic_cap[%0d]: got %h expected %h", i,
                         (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 'x, exp_cap[i]);
            end
        end
        n_checks++;
        if (frame_cnt !== 32'd2 || busy !== 1'b0 || m_valid !== 1'b0 || fwd_cnt - fwd_base !== 9) begin
            n_fail++;
            $display("FAIL basic_final: got cnt=%0d busy=%b m_valid=%b fwd=%0d expected 2 0 0 9",
                     frame_cnt, busy, m_valid, fwd_cnt - fwd_base);
        end
    endtask

    task automatic test_gapped();
        logic [AW-1:0] exp_cap[$];
        exp_cap = '{32'd10, 32'd26};
        do_reset();
        acc_len = 16'd4;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(DW'(i), 1'b1, 1'b1);
            send(DW'(100 + i), 1'b0, 1'b1);
        end
        send(16'd9, 1'b1, 1'b0);
        idle(6);
        n_checks++;
        if (cap_q.size() - cap_base !== 2 || fwd_cnt - fwd_base !== 9) begin
            n_fail++;
            $display("FAIL gapped_counts: got caps=%0d fwd=%0d expected 2 9", cap_q.size() - cap_base, fwd_cnt - fwd_base);
        end
        foreach (exp_cap[i]) begin
            n_checks++;
            if (cap_base + i >= cap_q.size() || cap_q[cap_base + i] !== exp_cap[i]) begin
                n_fail++;
                $display("FAIL gapped_cap[%0d]: got %h expected %h", i,
                         (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 'x, exp_cap[i]);
            end
        end
        n_checks++;
        if (frame_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL gapped_frame_cnt: got %0d expected 2", frame_cnt);
        end
    endtask

    task automatic test_len_zero();
        logic [DW-1:0] exp_done[$];
        logic [AW-1:0] exp_cap[$];
        exp_done = '{16'hFFFD, 16'd5, 16'd7, 16'd0};
        exp_cap  = '{32'hFFFF_FFFD, 32'd5, 32'd7};
        do_reset();
        acc_len = 16'd0;
        m_ready = 1'b1;
        send(16'hFFFD, 1'b1, 1'b1);
        send(16'd5, 1'b1, 1'b1);
        send(16'd7, 1'b1, 1'b1);
        send(16'd1, 1'b1, 1'b0);
        idle(6);
        foreach (exp_done[i]) begin
            n_checks++;
            if (done_base + i >= done_q.size() || done_q[done_base + i] !== exp_done[i]) begin
                n_fail++;
                $display("FAIL len0_done[%0d]: got %h expected %h", i,
                         (done_base + i < done_q.size()) ? done_q[done_base + i] : 'x, exp_done[i]);
            end
        end
        foreach (exp_cap[i]) begin
            n_checks++;
            if (cap_base + i >= cap_q.size() || cap_q[cap_base + i] !== exp_cap[i]) begin
                n_fail++;
                $display("FAIL len0_cap[%0d]: got %h expected %h", i,
                         (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 'x, exp_cap[i]);
            end
        end
        n_checks++;
        if (frame_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL len0_frame_cnt: got %0d expected 3", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        do_reset();
        acc_len = 16'd2;
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(DW'(i), 1'b1, 1'b1);
        for (int k = 0; k < 6 && !found; k++) begin
            tick();
            din_valid = 1'b0;
            if (acc_dout_valid && m_valid) begin
                clear_overrun = 1'b1;
                found = 1'b1;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_second_result: got none expected result while m_valid held");
        end
        tick();
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || m_dout !== 32'd3 || frame_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_overrun_set: got ovr=%b m_dout=%0d cnt=%0d expected 1 3 1", overrun, m_dout, frame_cnt);
        end
        tick();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_overrun_clear: got %b expected 0", overrun);
        end
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || cap_q.size() - cap_base !== 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got m_valid=%b caps=%0d busy=%b expected 0 1 1",
                     m_valid, cap_q.size() - cap_base, busy);
        end
        n_checks++;
        if (cap_base >= cap_q.size() || cap_q[cap_base] !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_accept_data: got %h expected 3",
                     (cap_base < cap_q.size()) ? cap_q[cap_base] : 'x);
        end
    endtask

    task automatic test_len_change();
        logic [DW-1:0] exp_done[$];
        logic [AW-1:0] exp_cap[$];
        exp_done = '{16'd1, 16'd5, 16'd7, 16'd0};
        exp_cap  = '{32'd10, 32'd11, 32'd15};
        do_reset();
        acc_len = 16'd4;
        m_ready = 1'b1;
        send(16'd1, 1'b1, 1'b1);
        send(16'd2, 1'b1, 1'b1);
        acc_len = 16'd2;
        for (int i = 3; i <= 8; i++) send(DW'(i), 1'b1, 1'b1);
        send(16'd9, 1'b1, 1'b0);
        idle(6);
        foreach (exp_done[i]) begin
            n_checks++;
            if (done_base + i >= done_q.size() || done_q[done_base + i] !== exp_done[i]) begin
                n_fail++;
                $display("FAIL lenchg_done[%0d]: got %h expected %h", i,
                         (done_base + i < done_q.size()) ? done_q[done_base + i] : 'x, exp_done[i]);
            end
        end
        foreach (exp_cap[i]) begin
            n_checks++;
            if (cap_base + i >= cap_q.size() || cap_q[cap_base + i] !== exp_cap[i]) begin
                n_fail++;
                $display("FAIL lenchg_cap[%0d]: got %h expected %h", i,
                         (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 'x, exp_cap[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW+AW+CW+5-1:0] outs;
        do_reset();
        acc_len = 16'd4;
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(DW'(i), 1'b1, 1'b1);
        idle(2);
        n_checks++;
        if (m_valid !== 1'b1 || m_dout !== 32'd10 || frame_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL arst_pre: got m_valid=%b m_dout=%0d cnt=%0d expected 1 10 1", m_valid, m_dout, frame_cnt);
        end
        // Reset the DUT only; the accumulator keeps its partial sum (5+6).
        rst_n = 1'b0;
        #1;
        outs = {acc_din, acc_din_valid, acc_done, m_dout, m_valid, overrun, frame_cnt, busy};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: got %h expected 0", outs);
        end
        tick();
        tick();
        rst_n     = 1'b1;
        m_ready   = 1'b1;
        done_base = done_q.size();
        cap_base  = cap_q.size();
        send(16'd10, 1'b1, 1'b1);
        send(16'd20, 1'b1, 1'b1);
        send(16'd30, 1'b1, 1'b1);
        send(16'd40, 1'b1, 1'b1);
        send(16'd50, 1'b1, 1'b0);
        idle(6);
        n_checks++;
        if (cap_q.size() - cap_base !== 1 || frame_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL arst_after_count: got caps=%0d cnt=%0d expected 1 1", cap_q.size() - cap_base, frame_cnt);
        end
        n_checks++;
        if (cap_base >= cap_q.size() || cap_q[cap_base] !== 32'd100) begin
            n_fail++;
            $display("FAIL arst_after_data: got %h expected 64",
                     (cap_base < cap_q.size()) ? cap_q[cap_base] : 'x);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_len_zero();
        test_backpressure();
        test_len_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
